// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, command bytes, default timing and frame helpers.
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StSend,
    StAck,
    StWaitIdle
  } ps2_state_e;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RESP_ACK     = 8'hFA;

  localparam int unsigned DEF_INHIBIT_CYCLES = 12000;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1500000;
  localparam int unsigned DEF_FILT_LEN       = 8;

  localparam int unsigned FRAME_BITS = 10;

  // {stop, odd parity, d7..d0}; shifted out LSB first
  function automatic logic [FRAME_BITS-1:0] ps2_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 clock deglitcher: a window of raw samples yields a clean falling-edge strobe and a
// "clock idle high" level.
module ps2_clk_filter #(
  parameter int unsigned FILT_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2clk,
  output logic fall,
  output logic clk_high
);

  localparam int unsigned Half = FILT_LEN / 2;

  logic [FILT_LEN-1:0] samples;

  always_ff @(posedge clk) begin
    if (!reset) begin
      samples <= '0;
    end else begin
      samples <= {samples[FILT_LEN-2:0], ps2clk};
    end
  end

  // Oldest half high, newest half low: matches exactly once per clean falling edge
  assign fall     = (&samples[FILT_LEN-1:Half]) & ~(|samples[Half-1:0]);
  assign clk_high = &samples;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, start bit, device-clocked frame, ACK check.
// Pins are driven only through open-drain pull-low enables.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned FILT_LEN       = DEF_FILT_LEN
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       ps2clk,
  input  logic       ps2data,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       ps2clk_low,
  output logic       ps2data_low,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy
);

  localparam int unsigned CntMax = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                     : TIMEOUT_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] InhibitLast = CntW'(INHIBIT_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      LastEdge    = 4'(FRAME_BITS - 1);

  ps2_state_e            state;
  logic [FRAME_BITS-1:0] shift;
  logic [CntW-1:0]       cnt;
  logic [3:0]            edge_cnt;
  logic [1:0]            data_sync;
  logic                  ps2data_s;
  logic                  fall;
  logic                  clk_high;

  ps2_clk_filter #(
    .FILT_LEN(FILT_LEN)
  ) u_clk_filter (
    .clk     (clk_100MHz),
    .reset   (reset),
    .ps2clk  (ps2clk),
    .fall    (fall),
    .clk_high(clk_high)
  );

  assign ps2data_s = data_sync[1];
  assign busy      = (state != StIdle);
  // Held low during the done/error pulse so a held request cannot overlap the report
  assign tx_ready  = (state == StIdle) && !tx_done && !tx_error;

  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      state       <= StIdle;
      shift       <= '0;
      cnt         <= '0;
      edge_cnt    <= '0;
      data_sync   <= '0;
      ps2clk_low  <= 1'b0;
      ps2data_low <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
    end else begin
      data_sync <= {data_sync[0], ps2data};
      tx_done   <= 1'b0;
      tx_error  <= 1'b0;
      unique case (state)
        StIdle: begin
          if (tx_valid && tx_ready) begin
            shift      <= ps2_frame(tx_data);
            ps2clk_low <= 1'b1;
            cnt        <= '0;
            state      <= StInhibit;
          end
        end
        StInhibit: begin
          if (cnt == InhibitLast) begin
            ps2clk_low  <= 1'b0;
            ps2data_low <= 1'b1;
            cnt         <= '0;
            edge_cnt    <= '0;
            state       <= StSend;
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
        StSend, StAck, StWaitIdle: begin
          // Timeout has priority over any coincident clock edge
          if (cnt == TimeoutLast) begin
            ps2clk_low  <= 1'b0;
            ps2data_low <= 1'b0;
            tx_error    <= 1'b1;
            state       <= StIdle;
          end else begin
            cnt <= cnt + CntW'(1);
            case (state)
              StSend: begin
                if (fall) begin
                  // Tenth edge drives ~stop = 0, releasing the line
                  ps2data_low <= ~shift[0];
                  shift       <= {1'b0, shift[FRAME_BITS-1:1]};
                  edge_cnt    <= edge_cnt + 4'd1;
                  if (edge_cnt == LastEdge) begin
                    state <= StAck;
                  end
                end
              end
              StAck: begin
                if (fall) begin
                  if (!ps2data_s) begin
                    state <= StWaitIdle;
                  end else begin
                    tx_error <= 1'b1;
                    state    <= StIdle;
                  end
                end
              end
              StWaitIdle: begin
                if (clk_high && ps2data_s) begin
                  tx_done <= 1'b1;
                  state   <= StIdle;
                end
              end
              default: ;
            endcase
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends one command byte to the keyboard, e.g. 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset).
- Implements the full host-request sequence: inhibit the clock, send start bit, send the frame on device-generated clock edges, then check the device ACK.
- Sits beside the keyboard scancode receiver on the same ps2clk/ps2data pins, in the clk_100MHz domain.
- Drives the pins only through open-drain "pull low" enables; the top level builds the tri-states.

Parameters:
- INHIBIT_CYCLES, 12000, clocks the host holds ps2clk low before the start bit (120 us at 100 MHz).
- TIMEOUT_CYCLES, 1500000, maximum clocks from clock release to ACK sample (15 ms).
- FILT_LEN, 8, ps2clk sample window length; must be even.

Ports:
- clk_100MHz  in  1  system clock
- reset  in  1  reset; synchronous, active-low
- ps2clk  in  1  raw PS/2 clock pin level
- ps2data  in  1  raw PS/2 data pin level
- tx_data  in  8  command byte
- tx_valid  in  1  request; byte accepted when tx_valid && tx_ready
- tx_ready  out  1  high only in IDLE
- ps2clk_low  out  1  1 = drive ps2clk pin to 0; 0 = release
- ps2data_low  out  1  1 = drive ps2data pin to 0; 0 = release
- tx_done  out  1  one-cycle pulse: frame sent and ACK received
- tx_error  out  1  one-cycle pulse: no ACK or timeout
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE; tx_ready=1; busy=0; ps2clk_low=0; ps2data_low=0; tx_done=0; tx_error=0; all counters, shift register and filter cleared. Applies mid-frame too: both lines are released the following cycle, with no partial-frame completion.
- Clock filter: FILT_LEN-bit shift register of ps2clk samples.
  - fall = upper half all 1s and lower half all 0s.
  - clk_high = all bits 1.
- Data input: ps2data passes through a 2-flop synchroniser; the synchronised value is ps2data_s.
- Frame: shift = {stop=1, parity, d7..d0}. Parity is odd: parity = ~^tx_data. Bits go out LSB first.
- States:
  - IDLE: on accept, latch the frame, set ps2clk_low=1, clear the cycle counter, go to INHIBIT.
  - INHIBIT: count INHIBIT_CYCLES. On expiry set ps2data_low=1 (start bit), clear ps2clk_low, clear the timeout counter and edge counter, go to SEND. The filter ignores edges caused by the host's own drive, because edges are counted only in SEND and ACK.
  - SEND: on each fall, increment the edge counter.
    - Edges 1..9: ps2data_low = ~shift[edge-1], i.e. d0..d7 then parity.
    - Edge 10: ps2data_low=0 (stop bit), go to ACK.
    - ps2data_low changes exactly 1 cycle after the cycle in which fall is asserted.
  - ACK: on the next fall, sample ps2data_s. A 0 goes to WAIT_IDLE; a 1 raises tx_error and goes to IDLE.
  - WAIT_IDLE: wait until clk_high && ps2data_s==1, then pulse tx_done and go to IDLE.
- Timeout: the counter runs during SEND, ACK and WAIT_IDLE. At TIMEOUT_CYCLES it releases both lines, pulses tx_error and goes to IDLE. If timeout and a fall coincide, the timeout wins.
- tx_valid while busy: ignored, no queueing; tx_data is held internally after accept.
- tx_done and tx_error are mutually exclusive and each lasts exactly 1 cycle. tx_ready returns high in the cycle after either pulse.
- ps2clk_low is high only in INHIBIT. ps2data_low is never high in IDLE, ACK or WAIT_IDLE.
- The counters saturate or clear on state entry; there is no wrap-around path.

Decomposition:
- Package ps2_pkg holds:
  - state enum: IDLE, INHIBIT, SEND, ACK, WAIT_IDLE;
  - PS/2 command constants: 0xED, 0xF4, 0xFF, 0xFA (device ACK byte);
  - default timing constants;
  - FRAME_BITS = 10.
- Sub-module ps2_clk_filter contains the sample shift register and produces fall and clk_high. It is reusable by the receiver.

Test Plan:
- Send 0xED with the device model clocking at 12.5 kHz and ACKing → ps2clk_low high for exactly 12000 cycles; data bits seen at the device are 0,1,0,1,1,0,1,1,1,1,1 (start, d0..d7, parity=1, stop=1); tx_done pulses once; tx_error stays 0.
- Send 0xF4 (parity 0) → device captures d0..d7 = 0,0,1,0,1,1,1,1, parity 0, stop 1; tx_done pulses.
- Device never clocks after release → tx_error pulses exactly TIMEOUT_CYCLES cycles after INHIBIT exit; both *_low = 0; tx_ready = 1.
- Device holds ps2data=1 at the ACK edge → tx_error pulses; no tx_done.
- reset driven low during SEND at edge 5 → next cycle: ps2clk_low=0, ps2data_low=0, tx_ready=1. A fresh 0xFF after reset is released completes normally.
- tx_valid held high with 0x00 during a 0xED frame → the second byte is not accepted until tx_ready; the first frame is unaffected.
